// File: rtl/cmac_pkg.sv
// Shared types and helpers for the CMAC link bring-up logic.
package cmac_pkg;

   localparam int RETRY_W = 8;
   localparam int LOSS_W  = 16;
   localparam int TIMER_W = 32;

   // Link sequencer states; encoding is visible in status readback.
   typedef enum logic [1:0] {
      HOLD       = 2'd0,
      RESET      = 2'd1,
      WAIT_ALIGN = 2'd2,
      LINK_UP    = 2'd3
   } state_t;

   // CMAC control/status outputs decoded from the state.
   typedef struct packed {
      logic sys_reset;
      logic rx_en;
      logic tx_en;
      logic rfi;
      logic link_up;
   } ctl_t;

   // Output decode for a given state. Unknown encodings fall back to the
   // safe HOLD values (core held in reset, nothing enabled).
   function automatic ctl_t decode_ctl(input state_t st);
      ctl_t c;
      case (st)
         HOLD, RESET: c = '{sys_reset: 1'b1, rx_en: 1'b0, tx_en: 1'b0, rfi: 1'b0, link_up: 1'b0};
         WAIT_ALIGN:  c = '{sys_reset: 1'b0, rx_en: 1'b1, tx_en: 1'b0, rfi: 1'b1, link_up: 1'b0};
         LINK_UP:     c = '{sys_reset: 1'b0, rx_en: 1'b1, tx_en: 1'b1, rfi: 1'b0, link_up: 1'b1};
         default:     c = '{sys_reset: 1'b1, rx_en: 1'b0, tx_en: 1'b0, rfi: 1'b0, link_up: 1'b0};
      endcase
      return c;
   endfunction

   // Saturating increment: an all-ones count stays all-ones.
   function automatic logic [RETRY_W-1:0] sat_inc(input logic [RETRY_W-1:0] v);
      logic [RETRY_W-1:0] r;
      if (v == {RETRY_W{1'b1}}) begin
         r = v;
      end else begin
         r = v + 8'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/cmac_link_sequencer_sync_bit.sv
// Two-flop synchronizer for a single asynchronous status bit.
module sync_bit (
   input  logic clk,
   input  logic resetn,
   input  logic d,
   output logic q
);

   (* ASYNC_REG = "TRUE" *) logic meta_r;
   (* ASYNC_REG = "TRUE" *) logic sync_r;

   // Two-stage capture of the asynchronous input; q lags d by two edges.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         meta_r <= 1'b0;
         sync_r <= 1'b0;
      end else begin
         meta_r <= d;
         sync_r <= meta_r;
      end
   end

   assign q = sync_r;

endmodule

// File: rtl/cmac_link_sequencer.sv
// CMAC link bring-up: reset pulse, wait for RX alignment with RFI,
// enable TX on link up, retry on timeout, filtered loss detection.
module cmac_link_sequencer
   import cmac_pkg::*;
#(
   parameter int unsigned RESET_CYCLES  = 1000,
   parameter int unsigned ALIGN_TIMEOUT = 50000000,
   parameter int unsigned LOSS_FILTER   = 16
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       startup_reset,
   input  logic       stat_rx_aligned,
   output logic       sys_reset,
   output logic       ctl_rx_enable,
   output logic       ctl_tx_enable,
   output logic       ctl_tx_send_rfi,
   output logic       link_up,
   output logic [7:0] retry_count
);

   // Timer reload values are "count minus one" because the state exits on
   // the cycle the timer reads zero.
   localparam logic [TIMER_W-1:0] RESET_LOAD = 32'(RESET_CYCLES - 32'd1);
   localparam logic [TIMER_W-1:0] ALIGN_LOAD = 32'(ALIGN_TIMEOUT - 32'd1);
   localparam logic [LOSS_W-1:0]  LOSS_MATCH = 16'(LOSS_FILTER);

   state_t               state_r;
   state_t               state_nxt_s;
   logic [TIMER_W-1:0]   timer_r;
   logic [TIMER_W-1:0]   timer_nxt_s;
   logic [LOSS_W-1:0]    loss_r;
   logic [LOSS_W-1:0]    loss_nxt_s;
   logic [LOSS_W-1:0]    loss_inc_s;
   logic [RETRY_W-1:0]   retry_r;
   logic [RETRY_W-1:0]   retry_nxt_s;
   ctl_t                 ctl_r;
   logic                 aligned_s;

   sync_bit u_sync_aligned (
      .clk    (clk),
      .resetn (resetn),
      .d      (stat_rx_aligned),
      .q      (aligned_s)
   );

   assign loss_inc_s = loss_r + 16'd1;

   // Next-state, timer and counter logic. startup_reset overrides all else.
   always_comb begin
      state_nxt_s = state_r;
      timer_nxt_s = timer_r;
      loss_nxt_s  = loss_r;
      retry_nxt_s = retry_r;
      if (startup_reset) begin
         state_nxt_s = HOLD;
         timer_nxt_s = 32'd0;
         loss_nxt_s  = 16'd0;
      end else begin
         case (state_r)
            HOLD: begin
               state_nxt_s = RESET;
               timer_nxt_s = RESET_LOAD;
            end
            RESET: begin
               if (timer_r == 32'd0) begin
                  state_nxt_s = WAIT_ALIGN;
                  timer_nxt_s = ALIGN_LOAD;
               end else begin
                  timer_nxt_s = timer_r - 32'd1;
               end
            end
            WAIT_ALIGN: begin
               // Alignment is checked first so it wins over a coincident timeout.
               if (aligned_s) begin
                  state_nxt_s = LINK_UP;
                  loss_nxt_s  = 16'd0;
               end else if (timer_r == 32'd0) begin
                  state_nxt_s = RESET;
                  timer_nxt_s = RESET_LOAD;
                  retry_nxt_s = sat_inc(retry_r);
               end else begin
                  timer_nxt_s = timer_r - 32'd1;
               end
            end
            LINK_UP: begin
               if (aligned_s) begin
                  loss_nxt_s = 16'd0;
               end else if (loss_inc_s == LOSS_MATCH) begin
                  state_nxt_s = WAIT_ALIGN;
                  timer_nxt_s = ALIGN_LOAD;
                  loss_nxt_s  = 16'd0;
               end else begin
                  loss_nxt_s = loss_inc_s;
               end
            end
            default: begin
               state_nxt_s = HOLD;
               timer_nxt_s = 32'd0;
               loss_nxt_s  = 16'd0;
            end
         endcase
      end
   end

   // State, timer, counters and output register; outputs track the state.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r <= HOLD;
         timer_r <= 32'd0;
         loss_r  <= 16'd0;
         retry_r <= 8'd0;
         ctl_r   <= decode_ctl(HOLD);
      end else begin
         state_r <= state_nxt_s;
         timer_r <= timer_nxt_s;
         loss_r  <= loss_nxt_s;
         retry_r <= retry_nxt_s;
         ctl_r   <= decode_ctl(state_nxt_s);
      end
   end

   assign sys_reset       = ctl_r.sys_reset;
   assign ctl_rx_enable   = ctl_r.rx_en;
   assign ctl_tx_enable   = ctl_r.tx_en;
   assign ctl_tx_send_rfi = ctl_r.rfi;
   assign link_up         = ctl_r.link_up;
   assign retry_count     = retry_r;

endmodule
